// File: rtl/ysyx_23060061_lsu_pkg.sv
// Shared encodings for the LSU: MemRW and funct3 codes, FSM states and AXI response codes.
// Also holds the request legality check that runs when a request is accepted.
package ysyx_23060061_lsu_pkg;

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b10;
  localparam logic [1:0] MEM_WRITE = 2'b01;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_RESP
  } state_t;

  // funct3[1:0] gives the access size for loads and stores alike.
  function automatic logic req_illegal(input logic [1:0] memrw, input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (memrw)
      MEM_READ:  bad = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      MEM_WRITE: bad = !(f3 inside {F3_SB, F3_SH, F3_SW});
      default:   bad = 1'b1;
    endcase
    if (f3[1:0] == 2'b01 && lo[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && lo != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_23060061_LoadExt.sv
// Combinational load extraction: picks the byte/half-word lane and sign/zero-extends it.
// Zero latency; no flow control.
module ysyx_23060061_LoadExt
  import ysyx_23060061_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = rdata[7:0];
    h   = rdata[15:0];
    ext = rdata;
    case (lane)
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    if (lane[1]) h = rdata[31:16];
    case (funct3)
      F3_LB:   ext = {{24{b[7]}}, b};
      F3_LBU:  ext = {24'b0, b};
      F3_LH:   ext = {{16{h[15]}}, h};
      F3_LHU:  ext = {16'b0, h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: one request at a time onto an AXI4-Lite data bus; zero-wait latency 3 cycles to resp_valid.
// Stalls the core while outstanding; bus valids hold until their handshake, illegal requests skip the bus.
module ysyx_23060061_lsu
  import ysyx_23060061_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        MemRW,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata_o,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q, aw_done, w_done;
  logic              accept, req_bad;
  logic [DATA_W-1:0] ext_data;
  logic [3:0]        strb;

  assign accept  = (state == S_IDLE) && req_valid && (MemRW != MEM_IDLE);
  assign req_bad = req_illegal(MemRW, funct3, addr[1:0]);

  ysyx_23060061_LoadExt u_load_ext (
    .rdata (rdata),
    .lane  (addr_q[1:0]),
    .funct3(funct3_q),
    .ext   (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    stall      = 1'b1;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (accept) begin
          if (req_bad)                 state_nxt = S_RESP;
          else if (MemRW == MEM_READ)  state_nxt = S_RD_ADDR;
          else                         state_nxt = S_WR;
        end
      end
      S_RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = S_RESP;
      end
      S_WR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        stall      = 1'b0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus addresses are word aligned; the lane lives in wstrb or in the load extraction.
  assign araddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign awaddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_rdata = rdata_q;

  always_comb begin
    strb    = 4'b1111;
    wdata_o = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        strb    = 4'b0001 << addr_q[1:0];
        wdata_o = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb    = 4'b0011 << addr_q[1:0];
        wdata_o = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
    wstrb = (state == S_WR) ? strb : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= addr;
        funct3_q <= funct3;
        wdata_q  <= wdata;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        if (req_bad) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
      if (state == S_RD_DATA && rvalid) begin
        err_q   <= (rresp != AXI_OKAY);
        rdata_q <= (rresp == AXI_OKAY) ? ext_data : '0;
      end
      if (state == S_WR) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
      if (state == S_WR_RESP && bvalid) begin
        err_q   <= (bresp != AXI_OKAY);
        rdata_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// Directed bench for ysyx_23060061_lsu with a negedge-driven AXI4-Lite slave model.
module tb_ysyx_23060061_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  MemRW;
  logic [2:0]  funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata_o, rdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  logic [31:0] mem_word;
  logic [1:0]  rresp_cfg, bresp_cfg;
  int          aw_delay, aw_cnt;

  int errors = 0;
  int checks = 0;

  // Observations from the last issued request.
  int          lat, nresp, ar_cyc, aw_cyc, w_cyc, stall_bad, rdy_after;
  logic [31:0] obs_rdata, obs_araddr, obs_awaddr, obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_err;

  always #5 clk = ~clk;

  ysyx_23060061_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemRW(MemRW), .funct3(funct3), .addr(req_addr), .wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Slave: answers at the negedge so a handshake lands on the next posedge (zero wait).
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; aw_cnt = 0;
    end else begin
      arready = arvalid;
      rvalid  = rready;
      rdata   = mem_word;
      rresp   = rresp_cfg;
      awready = awvalid && (aw_cnt >= aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid;
      bvalid  = bready;
      bresp   = bresp_cfg;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic issue(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int budget);
    lat = -1; nresp = 0; ar_cyc = 0; aw_cyc = 0; w_cyc = 0; stall_bad = 0; rdy_after = -1;
    obs_rdata = 'x; obs_err = 'x; obs_araddr = 'x; obs_awaddr = 'x; obs_wdata = 'x; obs_wstrb = 'x;
    @(negedge clk);
    req_valid = 1; MemRW = rw; funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin req_valid = 0; MemRW = 2'b00; end
      if (arvalid) begin
        if (ar_cyc == 0) obs_araddr = araddr;
        ar_cyc++;
      end
      if (awvalid) begin
        if (aw_cyc == 0) obs_awaddr = awaddr;
        aw_cyc++;
      end
      if (wvalid) begin
        if (w_cyc == 0) begin obs_wdata = wdata_o; obs_wstrb = wstrb; end
        w_cyc++;
      end
      if (lat < 0 && !resp_valid && stall !== 1'b1) stall_bad++;
      if (lat > 0 && k == lat + 1) rdy_after = int'(req_ready);
      if (resp_valid) begin
        nresp++;
        if (lat < 0) begin lat = k; obs_rdata = resp_rdata; obs_err = resp_err; end
      end
      if (lat > 0 && k >= lat + 2) break;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err, stall} !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000000", {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid, resp_err, stall});
    end
    checks++;
    if ({araddr, awaddr, resp_rdata} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: araddr=%h awaddr=%h rdata=%h expected all 0", araddr, awaddr, resp_rdata);
    end
    @(negedge clk); rst = 0;
  endtask

  task automatic test_store_word;
    issue(2'b01, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 20);
    checks++;
    if (obs_awaddr !== 32'h8000_0004) begin errors++; $display("FAIL sw_awaddr: got %h expected 80000004", obs_awaddr); end
    checks++;
    if (obs_wstrb !== 4'b1111 || obs_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_wdata: got strb=%b data=%h expected 1111 deadbeef", obs_wstrb, obs_wdata);
    end
    checks++;
    if (lat !== 3 || obs_err !== 1'b0 || nresp !== 1) begin
      errors++; $display("FAIL sw_resp: lat=%0d err=%b n=%0d expected 3 0 1", lat, obs_err, nresp);
    end
    checks++;
    if (rdy_after !== 1 || stall_bad !== 0) begin
      errors++; $display("FAIL sw_stall: ready_after=%0d stall_bad=%0d expected 1 0", rdy_after, stall_bad);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [6] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b100, 3'b010};
    logic [31:0] ads [6] = '{32'h8000_0101, 32'h8000_0103, 32'h8000_0102, 32'h8000_0102, 32'h8000_0103, 32'h8000_0100};
    logic [31:0] exp [6] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_80F1, 32'hFFFF_80F1, 32'h0000_0080, 32'h80F1_7F02};
    mem_word = 32'h80F1_7F02;
    for (int i = 0; i < 6; i++) begin
      issue(2'b10, f3s[i], ads[i], 32'h0, 20);
      checks++;
      if (obs_rdata !== exp[i] || obs_err !== 1'b0 || lat !== 3) begin
        errors++; $display("FAIL load_%0d: got data=%h err=%b lat=%0d expected %h 0 3", i, obs_rdata, obs_err, lat, exp[i]);
      end
      checks++;
      if (obs_araddr !== 32'h8000_0100 || ar_cyc !== 1) begin
        errors++; $display("FAIL load_araddr_%0d: got %h cycles=%0d expected 80000100 1", i, obs_araddr, ar_cyc);
      end
    end
  endtask

  task automatic test_store_narrow;
    issue(2'b01, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 20);
    checks++;
    if (obs_wstrb !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_lanes: got strb=%b data=%h expected 1100 abcdabcd", obs_wstrb, obs_wdata);
    end
    issue(2'b01, 3'b000, 32'h8000_0001, 32'h0000_005A, 20);
    checks++;
    if (obs_wstrb !== 4'b0010 || obs_wdata !== 32'h5A5A_5A5A || obs_err !== 1'b0) begin
      errors++; $display("FAIL sb_lanes: got strb=%b data=%h err=%b expected 0010 5a5a5a5a 0", obs_wstrb, obs_wdata, obs_err);
    end
  endtask

  task automatic test_aw_delay;
    aw_delay = 3;
    issue(2'b01, 3'b010, 32'h8000_0008, 32'h0102_0304, 30);
    aw_delay = 0;
    checks++;
    if (w_cyc !== 1 || aw_cyc !== 4) begin
      errors++; $display("FAIL awdelay_valids: got w=%0d aw=%0d cycles expected 1 4", w_cyc, aw_cyc);
    end
    checks++;
    if (stall_bad !== 0 || nresp !== 1 || lat !== 6) begin
      errors++; $display("FAIL awdelay_resp: stall_bad=%0d n=%0d lat=%0d expected 0 1 6", stall_bad, nresp, lat);
    end
  endtask

  task automatic test_errors;
    mem_word = 32'h1111_2222;
    issue(2'b10, 3'b010, 32'h8000_0002, 32'h0, 20);
    checks++;
    if (ar_cyc !== 0 || lat !== 1 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL lw_misaligned: ar=%0d lat=%0d err=%b data=%h expected 0 1 1 0", ar_cyc, lat, obs_err, obs_rdata);
    end
    issue(2'b11, 3'b010, 32'h8000_0000, 32'h0, 20);
    checks++;
    if (ar_cyc + aw_cyc !== 0 || lat !== 1 || obs_err !== 1'b1) begin
      errors++; $display("FAIL memrw_11: bus=%0d lat=%0d err=%b expected 0 1 1", ar_cyc + aw_cyc, lat, obs_err);
    end
    issue(2'b01, 3'b100, 32'h8000_0000, 32'h0, 20);
    checks++;
    if (aw_cyc !== 0 || lat !== 1 || obs_err !== 1'b1) begin
      errors++; $display("FAIL store_f3: aw=%0d lat=%0d err=%b expected 0 1 1", aw_cyc, lat, obs_err);
    end
    issue(2'b01, 3'b001, 32'h8000_0003, 32'h0, 20);
    checks++;
    if (aw_cyc !== 0 || obs_err !== 1'b1) begin
      errors++; $display("FAIL sh_misaligned: aw=%0d err=%b expected 0 1", aw_cyc, obs_err);
    end
    rresp_cfg = 2'b10;
    issue(2'b10, 3'b010, 32'h8000_0000, 32'h0, 20);
    rresp_cfg = 2'b00;
    checks++;
    if (lat !== 3 || obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL rresp_err: lat=%0d err=%b data=%h expected 3 1 0", lat, obs_err, obs_rdata);
    end
    bresp_cfg = 2'b11;
    issue(2'b01, 3'b010, 32'h8000_0000, 32'h0, 20);
    bresp_cfg = 2'b00;
    checks++;
    if (lat !== 3 || obs_err !== 1'b1) begin
      errors++; $display("FAIL bresp_err: lat=%0d err=%b expected 3 1", lat, obs_err);
    end
  endtask

  task automatic test_idle_ignore;
    issue(2'b00, 3'b010, 32'h8000_0000, 32'h0, 6);
    checks++;
    if (nresp !== 0 || ar_cyc + aw_cyc !== 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ignore: n=%0d bus=%0d ready=%b expected 0 0 1", nresp, ar_cyc + aw_cyc, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    mem_word = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1; MemRW = 2'b10; funct3 = 3'b010; req_addr = 32'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; MemRW = 2'b00;
    @(negedge clk);
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL midrst_setup: rready=%b expected 1", rready); end
    rst = 1;
    #1;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: arvalid=%b rready=%b ready=%b stall=%b expected 0 0 1 0", arvalid, rready, req_ready, stall);
    end
    @(negedge clk); rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL midrst_noresp: got %0d responses expected 0", n); end
    issue(2'b10, 3'b010, 32'h8000_0010, 32'h0, 20);
    checks++;
    if (obs_rdata !== 32'hCAFE_F00D || obs_err !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL midrst_after: data=%h err=%b lat=%0d expected cafef00d 0 3", obs_rdata, obs_err, lat);
    end
  endtask

  task automatic test_back_to_back;
    mem_word = 32'h0000_8001;
    issue(2'b10, 3'b001, 32'h8000_0020, 32'h0, 20);
    checks++;
    if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL b2b_lh: got %h expected ffff8001", obs_rdata); end
    issue(2'b10, 3'b101, 32'h8000_0020, 32'h0, 20);
    checks++;
    if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL b2b_lhu: got %h expected 00008001", obs_rdata); end
    checks++;
    if (resp_rdata !== 32'h0000_8001) begin errors++; $display("FAIL b2b_hold: got %h expected 00008001", resp_rdata); end
  endtask

  initial begin
    rst = 1; req_valid = 0; MemRW = 2'b00; funct3 = 3'b000; req_addr = 0; req_wdata = 0;
    mem_word = 0; rresp_cfg = 0; bresp_cfg = 0; aw_delay = 0;
    repeat (3) @(negedge clk);
    test_reset;
    test_store_word;
    test_loads;
    test_store_narrow;
    test_aw_delay;
    test_errors;
    test_idle_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
